// File: rtl/nn_pkg.sv
// Shared types and defaults for the MNIST accelerator output stages.
package nn_pkg;

  localparam int unsigned NUM_CLASSES_DEFAULT = 10;
  localparam int unsigned SCORE_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} argmax_state_t;

  typedef logic signed [SCORE_WIDTH_DEFAULT-1:0] score_t;

endpackage

// File: rtl/top2_update.sv
// Folds one score into a running (best, runner-up, best index) triple.
module top2_update #(
  parameter int unsigned SCORE_WIDTH = 32,
  parameter int unsigned IDX_W       = 4
) (
  input  logic signed [SCORE_WIDTH-1:0] best,
  input  logic signed [SCORE_WIDTH-1:0] second,
  input  logic        [IDX_W-1:0]       idx,
  input  logic signed [SCORE_WIDTH-1:0] s,
  input  logic        [IDX_W-1:0]       i,
  output logic signed [SCORE_WIDTH-1:0] best_nxt,
  output logic signed [SCORE_WIDTH-1:0] second_nxt,
  output logic        [IDX_W-1:0]       idx_nxt
);

  // Strict compares keep the lowest index on ties and let a tie set margin to 0.
  always_comb begin
    best_nxt   = best;
    second_nxt = second;
    idx_nxt    = idx;
    if (s > best) begin
      second_nxt = best;
      best_nxt   = s;
      idx_nxt    = i;
    end else if (s > second) begin
      second_nxt = s;
    end
  end

endmodule

// File: rtl/fc_argmax.sv
// Captures the FC output vector, scans it one score per cycle and returns
// argmax index, top score and margin over the runner-up via valid/ready.
module fc_argmax
  import nn_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEFAULT,
  parameter int unsigned SCORE_WIDTH = SCORE_WIDTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic signed [SCORE_WIDTH-1:0] scores [NUM_CLASSES],
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(NUM_CLASSES)-1:0] class_idx,
  output logic signed [SCORE_WIDTH-1:0] top_score,
  output logic        [SCORE_WIDTH:0]   margin
);

  localparam int unsigned IDX_W    = $clog2(NUM_CLASSES);
  localparam int unsigned MARGIN_W = SCORE_WIDTH + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
  localparam logic signed [SCORE_WIDTH-1:0] SCORE_MIN = {1'b1, {(SCORE_WIDTH-1){1'b0}}};

  argmax_state_t                 state;
  logic signed [SCORE_WIDTH-1:0] cap [NUM_CLASSES];
  logic signed [SCORE_WIDTH-1:0] best;
  logic signed [SCORE_WIDTH-1:0] second;
  logic        [IDX_W-1:0]       idx;
  logic        [IDX_W-1:0]       i;

  logic signed [SCORE_WIDTH-1:0] best_nxt;
  logic signed [SCORE_WIDTH-1:0] second_nxt;
  logic        [IDX_W-1:0]       idx_nxt;
  logic        [MARGIN_W-1:0]    margin_nxt;

  top2_update #(
    .SCORE_WIDTH(SCORE_WIDTH),
    .IDX_W      (IDX_W)
  ) u_top2 (
    .best      (best),
    .second    (second),
    .idx       (idx),
    .s         (cap[i]),
    .i         (i),
    .best_nxt  (best_nxt),
    .second_nxt(second_nxt),
    .idx_nxt   (idx_nxt)
  );

  // Sign-extended difference; best >= second always, so this is never negative.
  assign margin_nxt = {best_nxt[SCORE_WIDTH-1], best_nxt}
                    - {second_nxt[SCORE_WIDTH-1], second_nxt};

  // Snapshot of the vector; the scores input is not looked at again until the next start.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && start) begin
      cap <= scores;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      class_idx <= '0;
      top_score <= '0;
      margin    <= '0;
      best      <= '0;
      second    <= '0;
      idx       <= '0;
      i         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            best   <= scores[0];
            second <= SCORE_MIN;
            idx    <= '0;
            i      <= IDX_W'(1);
            busy   <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          best   <= best_nxt;
          second <= second_nxt;
          idx    <= idx_nxt;
          if (i == LAST_IDX) begin
            class_idx <= idx_nxt;
            top_score <= best_nxt;
            margin    <= margin_nxt;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            i <= i + IDX_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_argmax.sv
// Scoreboard bench for fc_argmax: expected results are queued at start and checked on out_valid.
module tb_fc_argmax;
  import nn_pkg::*;

  localparam int NC = 10;
  localparam int SW = 32;

  typedef struct packed {
    logic [3:0]           idx;
    logic signed [SW-1:0] top;
    logic [SW:0]          margin;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic signed [SW-1:0] scores [NC];
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0]           class_idx;
  logic signed [SW-1:0] top_score;
  logic [SW:0]          margin;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  fc_argmax #(.NUM_CLASSES(NC), .SCORE_WIDTH(SW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .scores   (scores),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .class_idx(class_idx),
    .top_score(top_score),
    .margin   (margin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: first strict maximum, runner-up is the max of all other entries.
  function automatic exp_t model(input logic signed [SW-1:0] v [NC]);
    exp_t   r;
    int     b;
    longint sec;
    b = 0;
    for (int j = 1; j < NC; j++) if (v[j] > v[b]) b = j;
    sec = -(longint'(1) <<< (SW - 1));
    for (int j = 0; j < NC; j++) if (j != b && longint'(v[j]) > sec) sec = longint'(v[j]);
    r.idx    = 4'(b);
    r.top    = v[b];
    r.margin = 33'(longint'(v[b]) - sec);
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic run_start(input logic signed [SW-1:0] v [NC]);
    scores = v;
    start  = 1'b1;
    q.push_back(model(v));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_result(output int lat, output bit to);
    lat = 0;
    to  = 1'b0;
    while (!out_valid) begin
      if (lat >= 40) begin
        to = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    for (int j = 0; j < NC; j++) scores[j] = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: busy=%b out_valid=%b, expected 0 0", busy, out_valid);
    end
    checks++;
    if (class_idx !== 4'd0 || top_score !== 32'sd0 || margin !== 33'd0) begin
      errors++; $display("FAIL reset_outputs: idx=%0d top=%0d margin=%0d, expected 0 0 0", class_idx, top_score, margin);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_distinct();
    logic signed [SW-1:0] v [NC];
    exp_t e; int lat; bit to;
    v = '{5, -3, 12, 0, 7, 1, 40, 2, -9, 39};
    run_start(v);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL distinct_busy: busy=%b, expected 1", busy); end
    wait_result(lat, to);
    checks++;
    if (to || lat != 9) begin errors++; $display("FAIL distinct_latency: %0d cycles (timeout=%0d), expected 9", lat, to); end
    e = q.pop_front();
    checks++;
    if (class_idx !== 4'd6 || top_score !== 32'sd40 || margin !== 33'd1) begin
      errors++; $display("FAIL distinct_result: idx=%0d top=%0d margin=%0d, expected 6 40 1", class_idx, top_score, margin);
    end
    checks++;
    if ({class_idx, top_score, margin} !== {e.idx, e.top, e.margin}) begin
      errors++; $display("FAIL distinct_model: idx=%0d top=%0d margin=%0d, expected %0d %0d %0d", class_idx, top_score, margin, e.idx, e.top, e.margin);
    end
    @(negedge clk);
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++; $display("FAIL distinct_handshake: busy=%b out_valid=%b, expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_tie();
    logic signed [SW-1:0] v [NC];
    exp_t e; int lat; bit to;
    for (int j = 0; j < NC; j++) v[j] = '0;
    v[2] = 32'sd100; v[5] = 32'sd100;
    run_start(v);
    wait_result(lat, to);
    e = q.pop_front();
    checks++;
    if (to || {class_idx, top_score, margin} !== {e.idx, e.top, e.margin}) begin
      errors++; $display("FAIL tie: idx=%0d top=%0d margin=%0d timeout=%0d, expected %0d %0d %0d", class_idx, top_score, margin, to, e.idx, e.top, e.margin);
    end
    @(negedge clk);
  endtask

  task automatic test_extremes();
    logic signed [SW-1:0] v [NC];
    exp_t e; int lat; bit to;
    for (int j = 0; j < NC; j++) v[j] = 32'sh8000_0000;
    v[9] = 32'sh7FFF_FFFF;
    run_start(v);
    wait_result(lat, to);
    e = q.pop_front();
    checks++;
    if (to || class_idx !== 4'd9 || margin !== 33'h0_FFFF_FFFF || top_score !== 32'sh7FFF_FFFF) begin
      errors++; $display("FAIL extreme_span: idx=%0d top=%0d margin=%0d timeout=%0d, expected 9 %0d %0d", class_idx, top_score, margin, to, e.top, e.margin);
    end
    @(negedge clk);
    v[9] = 32'sh8000_0000;
    run_start(v);
    wait_result(lat, to);
    e = q.pop_front();
    checks++;
    if (to || {class_idx, top_score, margin} !== {e.idx, e.top, e.margin}) begin
      errors++; $display("FAIL extreme_all_min: idx=%0d top=%0d margin=%0d timeout=%0d, expected %0d %0d %0d", class_idx, top_score, margin, to, e.idx, e.top, e.margin);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic signed [SW-1:0] v [NC];
    exp_t e; int lat; bit to;
    for (int j = 0; j < NC; j++) v[j] = SW'(j * 3 - 10);
    v[4] = 32'sd77; v[7] = 32'sd70;
    out_ready = 1'b0;
    run_start(v);
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < NC; j++) scores[j] = 32'sd1000 + SW'(j);
      start = c[0];
      @(negedge clk);
    end
    start = 1'b0;
    wait_result(lat, to);
    e = q.pop_front();
    checks++;
    if (to) begin errors++; $display("FAIL backpressure_timeout: out_valid=%b, expected 1", out_valid); end
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || {class_idx, top_score, margin} !== {e.idx, e.top, e.margin}) begin
        errors++; $display("FAIL backpressure_hold: cyc=%0d valid=%b idx=%0d top=%0d margin=%0d, expected 1 %0d %0d %0d", c, out_valid, class_idx, top_score, margin, e.idx, e.top, e.margin);
      end
      scores[c] = 32'sd5000;
      start = ~start;
      @(negedge clk);
    end
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++; $display("FAIL backpressure_handshake: busy=%b out_valid=%b, expected 0 0", busy, out_valid);
    end
    checks++;
    if ({class_idx, top_score, margin} !== {e.idx, e.top, e.margin}) begin
      errors++; $display("FAIL backpressure_after: idx=%0d top=%0d margin=%0d, expected %0d %0d %0d", class_idx, top_score, margin, e.idx, e.top, e.margin);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++; $display("FAIL backpressure_start_ignored: busy=%b out_valid=%b, expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic signed [SW-1:0] v [NC];
    exp_t e; int lat; bit to; bit seen;
    for (int j = 0; j < NC; j++) v[j] = SW'(20 - j);
    run_start(v);
    void'(q.pop_front());
    repeat (3) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checks++;
    if ({busy, out_valid} !== 2'b00 || class_idx !== 4'd0 || top_score !== 32'sd0 || margin !== 33'd0) begin
      errors++; $display("FAIL midscan_reset: busy=%b valid=%b idx=%0d top=%0d margin=%0d, expected 0 0 0 0 0", busy, out_valid, class_idx, top_score, margin);
    end
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (out_valid || busy) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midscan_no_pulse: activity seen=1, expected 0"); end
    v[3] = 32'sd99;
    run_start(v);
    wait_result(lat, to);
    e = q.pop_front();
    checks++;
    if (to || lat != 9 || {class_idx, top_score, margin} !== {e.idx, e.top, e.margin}) begin
      errors++; $display("FAIL midscan_restart: lat=%0d idx=%0d top=%0d margin=%0d, expected 9 %0d %0d %0d", lat, class_idx, top_score, margin, e.idx, e.top, e.margin);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic signed [SW-1:0] v [NC];
    exp_t e; int lat; bit to; int x;
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < NC; j++) begin
        x = int'($urandom_range(2097152, 0)) - 1048576;
        v[j] = x;
      end
      if (r == 1) v[8] = v[1];
      run_start(v);
      wait_result(lat, to);
      e = q.pop_front();
      checks++;
      if (to || lat != 9 || {class_idx, top_score, margin} !== {e.idx, e.top, e.margin}) begin
        errors++; $display("FAIL back_to_back run=%0d: lat=%0d idx=%0d top=%0d margin=%0d, expected 9 %0d %0d %0d", r, lat, class_idx, top_score, margin, e.idx, e.top, e.margin);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL back_to_back_handshake run=%0d: out_valid=%b, expected 0", r, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_distinct();
    test_tie();
    test_extremes();
    test_backpressure();
    test_reset_mid_scan();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
